mem_arbiter: RTL and testbench

//  Shares one unified memory port between the fetch stage (I port) and the load/store unit (D port).

---
 rtl/mem_arbiter_pkg.sv | 11 +
 rtl/mem_req_hold.sv | 14 +
 rtl/mem_arbiter.sv | 78 +++++++
 tb/tb_mem_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, arbiter state encoding and the memory request bundle.
package mem_arbiter_pkg;
  localparam int RISCV_ADDR_WIDTH = 32;
  localparam int RISCV_WORD_WIDTH = 32;
  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D} arb_state_t;
  typedef struct packed {
    logic [RISCV_ADDR_WIDTH-1:0] addr;
    logic [RISCV_WORD_WIDTH-1:0] wdata;
    logic [3:0]                  we;
  } mem_req_t;
endpackage

// File: rtl/mem_req_hold.sv
// mem_req_hold: registered addr/wdata/we capture with load enable and async clear.
module mem_req_hold
  import mem_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load,
  input  mem_req_t d,
  output mem_req_t q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (load) q <= d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch (I) and LSU (D), D-priority with
// an I starvation limit; holds issued requests and swallows responses to aborted ones.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_valid_i,
  output logic                        i_ready_o,
  input  logic [RISCV_ADDR_WIDTH-1:0] i_addr_i,
  input  logic [RISCV_WORD_WIDTH-1:0] i_wdata_i,
  input  logic [3:0]                  i_we_i,
  output logic [RISCV_WORD_WIDTH-1:0] i_rdata_o,
  input  logic                        d_valid_i,
  output logic                        d_ready_o,
  input  logic [RISCV_ADDR_WIDTH-1:0] d_addr_i,
  input  logic [RISCV_WORD_WIDTH-1:0] d_wdata_i,
  input  logic [3:0]                  d_we_i,
  output logic [RISCV_WORD_WIDTH-1:0] d_rdata_o,
  output logic                        mem_valid_o,
  input  logic                        mem_ready_i,
  output logic [RISCV_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [RISCV_WORD_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]                  mem_we_o,
  input  logic [RISCV_WORD_WIDTH-1:0] mem_rdata_i
);
  localparam int CW = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
  arb_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic abort, abort_nxt, idle, any_req, d_win, owner_valid, load;
  mem_req_t i_req, d_req, win_req, hold_q, out_req;
  assign i_req = '{addr: i_addr_i, wdata: i_wdata_i, we: i_we_i};
  assign d_req = '{addr: d_addr_i, wdata: d_wdata_i, we: d_we_i};
  mem_req_hold u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .d     (win_req),
    .q     (hold_q)
  );
  // An owner dropping valid in the completion cycle counts as an abort too.
  always_comb begin
    idle        = state == ARB_IDLE;
    any_req     = i_valid_i | d_valid_i;
    d_win       = d_valid_i && (!i_valid_i || cnt < CW'(STARVE_LIMIT));
    win_req     = d_win ? d_req : i_valid_i ? i_req : '0;
    owner_valid = state == ARB_BUSY_D ? d_valid_i : i_valid_i;
    mem_valid_o = rst_n && (!idle || any_req);
    out_req     = !mem_valid_o ? '0 : idle ? win_req : hold_q;
    i_ready_o   = mem_valid_o && mem_ready_i &&
                  (idle ? !d_win : state == ARB_BUSY_I && !abort && i_valid_i);
    d_ready_o   = mem_valid_o && mem_ready_i &&
                  (idle ? d_win : state == ARB_BUSY_D && !abort && d_valid_i);
    load        = idle && any_req && !mem_ready_i;
    state_nxt   = load ? (d_win ? ARB_BUSY_D : ARB_BUSY_I) :
                  (!idle && mem_ready_i) ? ARB_IDLE : state;
    abort_nxt   = (idle || mem_ready_i) ? 1'b0 : abort || !owner_valid;
    cnt_nxt     = !idle ? cnt : (!i_valid_i || !d_win) ? '0 :
                  cnt == CW'(STARVE_LIMIT) ? cnt : cnt + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ARB_IDLE;
      cnt   <= '0;
      abort <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      abort <= abort_nxt;
    end
  assign mem_addr_o  = out_req.addr;
  assign mem_wdata_o = out_req.wdata;
  assign mem_we_o    = out_req.we;
  assign i_rdata_o   = mem_rdata_i;
  assign d_rdata_o   = mem_rdata_i;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors against a small wait-state memory model.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv, dv, ir, dr, mv, mr;
  logic [31:0] ia, da, iw, dw, ird, drd, ma, mw, mrd;
  logic [3:0]  iwe, dwe, mwe;
  logic [31:0] mem [0:255];
  logic        clr_mem;
  int          wait_n, ws, n_wr, n_vec, n_err;
  logic [3:0]  wr_we;
  string       grants;
  always #5 clk = ~clk;
  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid_i(iv), .i_ready_o(ir), .i_addr_i(ia), .i_wdata_i(iw), .i_we_i(iwe), .i_rdata_o(ird),
    .d_valid_i(dv), .d_ready_o(dr), .d_addr_i(da), .d_wdata_i(dw), .d_we_i(dwe), .d_rdata_o(drd),
    .mem_valid_o(mv), .mem_ready_i(mr), .mem_addr_o(ma), .mem_wdata_o(mw), .mem_we_o(mwe),
    .mem_rdata_i(mrd)
  );
  assign mr  = mv && (ws == wait_n);
  assign mrd = mem[ma[9:2]];
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ws <= 0;
    else ws <= (!mv || mr) ? 0 : ws + 1;
  always @(posedge clk)
    if (clr_mem) begin
      for (int k = 0; k < 256; k++) mem[k] <= '0;
      n_wr  <= 0;
      wr_we <= '0;
    end else if (mv && mr && |mwe) begin
      for (int b = 0; b < 4; b++)
        if (mwe[b]) mem[ma[9:2]][8*b +: 8] <= mw[8*b +: 8];
      n_wr  <= n_wr + 1;
      wr_we <= mwe;
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic mid();
    @(negedge clk);
  endtask
  initial begin
    n_vec = 0; n_err = 0; clr_mem = 1'b1; wait_n = 0;
    grants = "DDDDIDDDDI";
    {iv, dv} = '0; {ia, da, iw, dw} = '0; {iwe, dwe} = '0;
    step();
    iv = 1'b1; ia = 32'h10;
    mid();
    check("rst_mem_valid", 32'(mv), 0);
    check("rst_mem_addr", ma, 0);
    check("rst_i_ready", 32'(ir), 0);
    check("rst_d_ready", 32'(dr), 0);
    check("rst_mem_we", 32'(mwe), 0);
    step();
    iv = 1'b0; clr_mem = 1'b0; rst_n = 1'b1;
    step();
    // 1: single-cycle memory, three back-to-back fetches
    for (int k = 0; k < 3; k++) begin
      iv = 1'b1; ia = 32'(4 * k);
      mid();
      check($sformatf("t1_i_ready%0d", k), 32'(ir), 1);
      check($sformatf("t1_addr%0d", k), ma, 32'(4 * k));
      check($sformatf("t1_d_ready%0d", k), 32'(dr), 0);
      step();
    end
    iv = 1'b0;
    step();
    // 2: both requesting, one wait state, starvation limit 4
    wait_n = 1; iv = 1'b1; dv = 1'b1; ia = 32'h200; da = 32'h300;
    for (int k = 0; k < 10; k++) begin
      mid();
      check($sformatf("t2_issue_addr%0d", k), ma, grants[k] == "D" ? 32'h300 : 32'h200);
      check($sformatf("t2_issue_rdy%0d", k), 32'({ir, dr}), 0);
      step();
      mid();
      check($sformatf("t2_i_ready%0d", k), 32'(ir), 32'(grants[k] == "I"));
      check($sformatf("t2_d_ready%0d", k), 32'(dr), 32'(grants[k] == "D"));
      step();
    end
    iv = 1'b0; dv = 1'b0;
    step();
    // 3: abort by dropping valid, then re-raise with a new address
    wait_n = 3; iv = 1'b1; ia = 32'h100;
    for (int c = 0; c < 8; c++) begin
      if (c == 1) begin iv = 1'b0; ia = 32'h200; end
      if (c == 2) iv = 1'b1;
      mid();
      check($sformatf("t3_valid%0d", c), 32'(mv), 1);
      check($sformatf("t3_addr%0d", c), ma, c < 4 ? 32'h100 : 32'h200);
      check($sformatf("t3_i_ready%0d", c), 32'(ir), 32'(c == 7));
      step();
    end
    iv = 1'b0;
    step();
    // 4: partial store by D while I waits, then read back
    wait_n = 1; dv = 1'b1; da = 32'h40; dwe = 4'b0011; dw = 32'hDEADBEEF; iv = 1'b1; ia = 32'h0;
    mid();
    check("t4_we", 32'(mwe), 32'h3);
    check("t4_addr", ma, 32'h40);
    check("t4_wdata", mw, 32'hDEADBEEF);
    step();
    mid();
    check("t4_d_ready", 32'(dr), 1);
    check("t4_i_ready_busy", 32'(ir), 0);
    step();
    dv = 1'b0; dwe = '0;
    mid();
    check("t4_i_addr", ma, 32'h0);
    check("t4_i_we", 32'(mwe), 0);
    step();
    mid();
    check("t4_i_ready", 32'(ir), 1);
    step();
    iv = 1'b0;
    check("t4_n_writes", 32'(n_wr), 1);
    check("t4_wr_we", 32'(wr_we), 32'h3);
    dv = 1'b1; da = 32'h40;
    step();
    mid();
    check("t4_rd_ready", 32'(dr), 1);
    check("t4_d_rdata", drd, 32'h0000BEEF);
    check("t4_i_rdata", ird, 32'h0000BEEF);
    step();
    dv = 1'b0;
    step();
    // 5: reset in the middle of a D transaction
    wait_n = 3; dv = 1'b1; da = 32'h80;
    step();
    mid();
    check("t5_busy_valid", 32'(mv), 1);
    step();
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(mv), 0);
    check("t5_rst_ready", 32'(dr), 0);
    check("t5_rst_addr", ma, 0);
    dv = 1'b0;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      mid();
      check($sformatf("t5_post_valid%0d", c), 32'(mv), 0);
      check($sformatf("t5_post_ready%0d", c), 32'({ir, dr}), 0);
      step();
    end
    // 6: memory ready in the issue cycle keeps the arbiter idle
    wait_n = 0; dv = 1'b1; da = 32'h44;
    mid();
    check("t6_d_ready", 32'(dr), 1);
    check("t6_addr", ma, 32'h44);
    step();
    dv = 1'b0;
    mid();
    check("t6_idle_valid", 32'(mv), 0);
    check("t6_idle_ready", 32'(dr), 0);
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
